maroc_sc_sequencer: RTL

Controller that schedules and supervises MAROC slow-control frame loads through the 829-bit serial transmitter. Arbitrates between host-requested loads and a periodic auto-refresh, pulses the transmitter start, tracks its state to completion with timeouts, and optionally verifies the load by a second pass comparing the chip's Q_SC readback against the transmitted D_SC stream, retrying on mismatch.

---
 rtl/maroc_sc_sequencer_if.sv | 20 ++
 rtl/maroc_sc_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/maroc_sc_sequencer_if.sv
// Host request handshake and serial-transmitter link of the MAROC slow-control sequencer.
// The master modport is the sequencer side; the slave modport is the host/transmitter side.
interface maroc_sc_sequencer_if;
  logic       host_req_in;
  logic       host_ack_out;
  logic       tx_start_out;
  logic [1:0] tx_state_in;
  logic       tx_d_sc_in;
  logic       q_sc_in;

  modport master (
    input  host_req_in, tx_state_in, tx_d_sc_in, q_sc_in,
    output host_ack_out, tx_start_out
  );

  modport slave (
    output host_req_in, tx_state_in, tx_d_sc_in, q_sc_in,
    input  host_ack_out, tx_start_out
  );
endinterface

// File: rtl/maroc_sc_sequencer.sv
// MAROC slow-control load sequencer: host/refresh arbitration, transmitter supervision with
// timeouts and retries. Define SC_READBACK_VERIFY_EN for the second Q_SC verify pass.
module maroc_sc_sequencer #(
  parameter int FRAME_BITS     = 829,
  parameter int REFRESH_PERIOD = 5000000,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  maroc_sc_sequencer_if.master link,
  input  logic                 refresh_en_in,
  input  logic                 err_clr_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic                 source_out,
  output logic [1:0]           retry_cnt_out,
  output logic [2:0]           state_out
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    WAIT_SEND   = 3'd2,
    WAIT_FINAL  = 3'd3,
    VSTART      = 3'd4,
    VWAIT_SEND  = 3'd5,
    VWAIT_FINAL = 3'd6,
    FAIL        = 3'd7
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + FRAME_BITS + 2);
  localparam int RW = $clog2(REFRESH_PERIOD + 1);
  localparam logic [1:0] TX_SENDING  = 2'd2;
  localparam logic [1:0] TX_FINAL    = 2'd3;
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] wait_cnt;
  logic [RW-1:0] refresh_cnt;
  logic          refresh_pending;
  logic          mismatch;

  logic          grant_host;
  logic          grant_refresh;
  logic          attempt_fail;
  logic          seq_pass;
  logic          seq_fail;
  logic          in_wait;
  logic          timed_out;
  logic          can_retry;
  logic          cmp_err;

  logic          tx_start_q, tx_start_d;
  logic          host_ack_q, host_ack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          source_q, source_d;
  logic [1:0]    retry_q, retry_d;

`ifdef SC_READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  logic cmp_window;
  // The readback window skips the entry cycle of VWAIT_FINAL and covers one frame.
  assign cmp_window = (state == VWAIT_FINAL) && (wait_cnt != '0) &&
                      (wait_cnt <= TW'(FRAME_BITS));
  assign cmp_err    = cmp_window && (link.tx_d_sc_in != link.q_sc_in);
`else
  localparam bit VERIFY = 1'b0;
  logic unused_readback;
  assign unused_readback = link.tx_d_sc_in ^ link.q_sc_in;
  assign cmp_err         = 1'b0;
`endif

  assign in_wait   = (state == WAIT_SEND) || (state == WAIT_FINAL) ||
                     (state == VWAIT_SEND) || (state == VWAIT_FINAL);
  assign timed_out = in_wait && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign can_retry = (retry_q < RETRY_LIMIT);
  assign seq_fail  = attempt_fail && !can_retry;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_host    = 1'b0;
    grant_refresh = 1'b0;
    attempt_fail  = 1'b0;
    seq_pass      = 1'b0;
    case (state)
      IDLE: begin
        if (link.host_req_in) begin
          state_nxt  = START;
          grant_host = 1'b1;
        end else if (refresh_pending) begin
          state_nxt     = START;
          grant_refresh = 1'b1;
        end
      end
      START:  state_nxt = WAIT_SEND;
      VSTART: state_nxt = VWAIT_SEND;
      WAIT_SEND: begin
        if (link.tx_state_in == TX_SENDING) state_nxt = WAIT_FINAL;
        else if (timed_out)                 attempt_fail = 1'b1;
      end
      WAIT_FINAL: begin
        if (link.tx_state_in == TX_FINAL) begin
          if (VERIFY) state_nxt = VSTART;
          else        seq_pass  = 1'b1;
        end else if (timed_out) begin
          attempt_fail = 1'b1;
        end
      end
      VWAIT_SEND: begin
        if (link.tx_state_in == TX_SENDING) state_nxt = VWAIT_FINAL;
        else if (timed_out)                 attempt_fail = 1'b1;
      end
      VWAIT_FINAL: begin
        // The final-cycle compare result is folded in so a late mismatch is not lost.
        if (link.tx_state_in == TX_FINAL) begin
          if (mismatch || cmp_err) attempt_fail = 1'b1;
          else                     seq_pass     = 1'b1;
        end else if (timed_out) begin
          attempt_fail = 1'b1;
        end
      end
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (seq_pass) begin
      state_nxt = IDLE;
    end else if (attempt_fail) begin
      state_nxt = can_retry ? START : FAIL;
    end
  end

  always_comb begin
    tx_start_d = (state == START) || (state == VSTART);
    host_ack_d = grant_host;
    busy_d     = (state_nxt != IDLE);
    done_d     = seq_pass || seq_fail;
    source_d   = source_q;
    retry_d    = retry_q;
    error_d    = error_q;
    if (grant_host) begin
      source_d = 1'b0;
      retry_d  = 2'd0;
    end else if (grant_refresh) begin
      source_d = 1'b1;
      retry_d  = 2'd0;
    end else if (attempt_fail && can_retry) begin
      retry_d  = retry_q + 2'd1;
    end
    if (seq_fail)        error_d = 1'b1;
    else if (err_clr_in) error_d = 1'b0;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      tx_start_q <= 1'b0;
      host_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      source_q   <= 1'b0;
      retry_q    <= 2'd0;
    end else begin
      tx_start_q <= tx_start_d;
      host_ack_q <= host_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      source_q   <= source_d;
      retry_q    <= retry_d;
    end
  end

  // Cycles spent in the current state; every state change restarts the count.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wait_cnt <= '0;
      mismatch <= 1'b0;
    end else begin
      if (state_nxt != state) wait_cnt <= '0;
      else if (in_wait)       wait_cnt <= wait_cnt + TW'(1);
      if (state != VWAIT_FINAL) mismatch <= 1'b0;
      else if (cmp_err)         mismatch <= 1'b1;
    end
  end

  // Only one refresh is ever queued; a grant in the expiry cycle consumes that expiry too.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      refresh_cnt     <= '0;
      refresh_pending <= 1'b0;
    end else if (!refresh_en_in) begin
      refresh_cnt     <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (refresh_cnt == RW'(REFRESH_PERIOD - 1)) begin
        refresh_cnt     <= '0;
        refresh_pending <= 1'b1;
      end else if (done_d) begin
        refresh_cnt <= '0;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      if (grant_refresh) refresh_pending <= 1'b0;
    end
  end

  assign link.tx_start_out = tx_start_q;
  assign link.host_ack_out = host_ack_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign error_out         = error_q;
  assign source_out        = source_q;
  assign retry_cnt_out     = retry_q;
  assign state_out         = state;

endmodule
